traffic_ctrl_param: RTL and testbench
=====================================

# traffic_ctrl_param

Parametrised two-road traffic-light controller: phase durations, second-tick prescale and counter width are set by parameters. It adds a flashing-yellow night mode, a defined both-force behaviour and fully synchronous control inputs. It sits between the board clock and the BCD/seven-segment display path. It drives six lamp outputs and two per-road remaining-seconds counters, plus a valid flag that tells the display to show dashes.

## Interface
- TICK_DIV, 25000000: clk_in cycles per one-second tick (≥2)
- G_A, 35: road A green seconds (≥1)
- G_B, 25: road B green seconds (≥1)
- Y, 5: yellow seconds, both roads (≥1)
- CNT_W, 8: width of cnt_a/cnt_b; G_A+Y and G_B+Y must be ≤ 2^CNT_W−1
- clk_in  in  1  system clock, rising edge
- clr  in  1  reset, asynchronous, active-high
- start  in  1  level; run the normal cycle
- force_a  in  1  level; road A held green (road B blocked)
- force_b  in  1  level; road B held green (road A blocked)
- flash  in  1  level; night mode, both yellows blink
- pause  in  1  level; freeze timing and lamps
- r_a, y_a, g_a  out  1 each  road A lamps
- r_b, y_b, g_b  out  1 each  road B lamps
- cnt_a, cnt_b  out  CNT_W each  remaining seconds of the current lamp, binary
- disp_valid  out  1  1 = counters meaningful; 0 = display dashes
- tick  out  1  one-cycle pulse per second (prescaler terminal count)
- state  out  3  FSM state encoding below

## Operation
- States: IDLE=0, A_GRN=1, A_YEL=2, B_GRN=3, B_YEL=4, FORCE=5, FLASH=6.
- All inputs are sampled on the clk_in rising edge. Control priority per cycle: force_a/force_b > flash > pause > start.
- IDLE: all reds on, disp_valid=0, prescaler held at 0. With start=1 and no higher-priority input, the next edge enters A_GRN.
- Entry to A_GRN: g_a, r_b on; cnt_a=G_A; cnt_b=G_A+Y; prescaler cleared.
- Each tick in a run state: if the owning phase count is 1, advance to the next state. Otherwise decrement both counters.
- A_GRN→A_YEL: y_a, r_b on; cnt_a=Y; cnt_b decrements normally.
- A_YEL→B_GRN: r_a, g_b on; cnt_a=G_B+Y; cnt_b=G_B.
- B_GRN→B_YEL: r_a, y_b on; cnt_b=Y; cnt_a decrements.
- B_YEL→A_GRN: reload as at A_GRN entry. The cycle repeats while start=1.
- start dropped in a run state: the current cycle completes. At the B_YEL→A_GRN boundary the FSM goes to IDLE instead.
- FORCE, force_a only: g_a, r_b on.
- FORCE, force_b only: r_a, g_b on.
- FORCE, both forces high: all reds on.
- In FORCE, disp_valid=0, counters are held at 0 and the prescaler is held at 0.
- FLASH: reds and greens off. y_a=y_b and both toggle on every tick, starting at 1 on entry. disp_valid=0, counters 0.
- Leaving FORCE or FLASH (input deasserted): enter A_GRN with a fresh load if start=1, else IDLE.
- pause in a run state: prescaler, counters, state and lamps all frozen. tick stays 0. Resume continues from the frozen prescaler value.
- pause in IDLE, FORCE or FLASH has no effect.
- Exactly one lamp per road is on in every state except FLASH, with the yellow-off half of FLASH showing all dark.

## Timing
- Reset values: state=IDLE; r_a=r_b=1; all other lamps 0; cnt_a=cnt_b=0; disp_valid=0; tick=0; prescaler=0.
- Input-to-output latency is 1 clk_in edge for all mode changes, including force, flash and start.
- The prescaler counts 0..TICK_DIV−1. tick=1 during the cycle when count=TICK_DIV−1. The state and counter update occurs on that edge.
- The first tick after A_GRN entry comes TICK_DIV cycles later, so the first second is full length.
- All lamp, counter and state outputs are registered; tick is registered.
- Full normal cycle = (G_A+Y+G_B+Y)·TICK_DIV cycles.
- clr mid-operation forces reset values immediately, independent of clk_in.
- Counter arithmetic: unsigned CNT_W. The counters never underflow because transitions happen at 1.

## Test plan
Parameters for all scenarios: TICK_DIV=4, G_A=3, G_B=2, Y=1.

- Reset, then start=1 → next edge: state=1, g_a=r_b=1, cnt_a=3, cnt_b=4, disp_valid=1. After 4 cycles: 2/3. After 12: y_a=1, 1/1. After 16: g_b=r_a=1, 3/2. After 24: y_b=1, 1/1. After 28: back to 3/4.
- pause held 10 cycles at cnt_a=2 → cnt, state and lamps unchanged, no tick. After release, next tick arrives after the remaining prescale cycles.
- force_a pulsed mid-B_GRN → next edge: g_a=r_b=1, disp_valid=0. Release with start=1 → A_GRN, 3/4.
- force_a and force_b both high → all reds, state=5. Drop force_b only → g_a=r_b=1.
- flash=1 for 12 cycles → y_a=y_b=1 for 4 cycles, 0 for 4, 1 for 4. Other lamps 0.
- clr asserted mid A_YEL, between edges → outputs at reset values without waiting for clk_in. start=0 after release → stays IDLE.

Source files
------------

// File: rtl/traffic_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module   : traffic_ctrl_param
// Purpose  : Two-road traffic-light controller with parametrised phase
//            lengths, one-second prescaler, force/flash/pause modes and
//            per-road remaining-seconds counters for a BCD display path.
// Revision : 1.0  initial release
// ============================================================================
module traffic_ctrl_param #(
  parameter int TICK_DIV = 25000000,
  parameter int G_A      = 35,
  parameter int G_B      = 25,
  parameter int Y        = 5,
  parameter int CNT_W    = 8
) (
  input  logic             clk_in,
  input  logic             clr,
  input  logic             start,
  input  logic             force_a,
  input  logic             force_b,
  input  logic             flash,
  input  logic             pause,
  output logic             r_a,
  output logic             y_a,
  output logic             g_a,
  output logic             r_b,
  output logic             y_b,
  output logic             g_b,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic             disp_valid,
  output logic             tick,
  output logic [2:0]       state
);

  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_A_GRN = 3'd1,
    S_A_YEL = 3'd2,
    S_B_GRN = 3'd3,
    S_B_YEL = 3'd4,
    S_FORCE = 3'd5,
    S_FLASH = 3'd6
  } state_t;

  localparam logic [PW-1:0]    c_presc_tc = PW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_ga       = CNT_W'(G_A);
  localparam logic [CNT_W-1:0] c_gb       = CNT_W'(G_B);
  localparam logic [CNT_W-1:0] c_y        = CNT_W'(Y);
  localparam logic [CNT_W-1:0] c_gay      = CNT_W'(G_A + Y);
  localparam logic [CNT_W-1:0] c_gby      = CNT_W'(G_B + Y);

  // Lamp vector order: {r_a, y_a, g_a, r_b, y_b, g_b}
  localparam logic [5:0] c_lamps_red   = 6'b100_100;
  localparam logic [5:0] c_lamps_a_grn = 6'b001_100;
  localparam logic [5:0] c_lamps_a_yel = 6'b010_100;
  localparam logic [5:0] c_lamps_b_grn = 6'b100_001;
  localparam logic [5:0] c_lamps_b_yel = 6'b100_010;

  state_t           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0] cnt_b_q, cnt_b_d;
  logic             flash_y_q, flash_y_d;
  logic             tick_q, tick_d;
  logic             dv_q, dv_d;
  logic [5:0]       lamps_q, lamps_d;

  logic w_tc;
  logic w_run;
  logic w_freeze;

  assign w_tc  = (presc_q == c_presc_tc);
  assign w_run = (state_q == S_A_GRN) || (state_q == S_A_YEL) ||
                 (state_q == S_B_GRN) || (state_q == S_B_YEL);

  // Next state, prescaler and counters; control priority force > flash > pause > start
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    cnt_a_d   = cnt_a_q;
    cnt_b_d   = cnt_b_q;
    flash_y_d = flash_y_q;
    w_freeze  = 1'b0;

    if (force_a || force_b) begin
      state_d   = S_FORCE;
      presc_d   = '0;
      cnt_a_d   = '0;
      cnt_b_d   = '0;
      flash_y_d = 1'b0;
    end else if (flash) begin
      cnt_a_d = '0;
      cnt_b_d = '0;
      if (state_q != S_FLASH) begin
        // Yellows come on immediately and the first blink second is full length
        state_d   = S_FLASH;
        presc_d   = '0;
        flash_y_d = 1'b1;
      end else if (w_tc) begin
        presc_d   = '0;
        flash_y_d = ~flash_y_q;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end else if (w_run && pause) begin
      // Everything holds, including the partial second in the prescaler
      w_freeze = 1'b1;
    end else if (!w_run) begin
      // IDLE, or leaving FORCE/FLASH: fresh start of the cycle or back to idle
      flash_y_d = 1'b0;
      presc_d   = '0;
      if (start) begin
        state_d = S_A_GRN;
        cnt_a_d = c_ga;
        cnt_b_d = c_gay;
      end else begin
        state_d = S_IDLE;
        cnt_a_d = '0;
        cnt_b_d = '0;
      end
    end else if (!w_tc) begin
      presc_d = presc_q + 1'b1;
    end else begin
      // One-second boundary: both counters step down unless the phase ends
      presc_d = '0;
      cnt_a_d = cnt_a_q - 1'b1;
      cnt_b_d = cnt_b_q - 1'b1;
      case (state_q)
        S_A_GRN: begin
          if (cnt_a_q == c_cnt_one) begin
            state_d = S_A_YEL;
            cnt_a_d = c_y;
          end
        end
        S_A_YEL: begin
          if (cnt_a_q == c_cnt_one) begin
            state_d = S_B_GRN;
            cnt_a_d = c_gby;
            cnt_b_d = c_gb;
          end
        end
        S_B_GRN: begin
          if (cnt_b_q == c_cnt_one) begin
            state_d = S_B_YEL;
            cnt_b_d = c_y;
          end
        end
        S_B_YEL: begin
          if (cnt_b_q == c_cnt_one) begin
            if (start) begin
              state_d = S_A_GRN;
              cnt_a_d = c_ga;
              cnt_b_d = c_gay;
            end else begin
              state_d = S_IDLE;
              cnt_a_d = '0;
              cnt_b_d = '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Lamp pattern, display-valid and tick derived from the upcoming state
  always_comb begin
    lamps_d = c_lamps_red;
    dv_d    = 1'b0;
    case (state_d)
      S_A_GRN: begin
        lamps_d = c_lamps_a_grn;
        dv_d    = 1'b1;
      end
      S_A_YEL: begin
        lamps_d = c_lamps_a_yel;
        dv_d    = 1'b1;
      end
      S_B_GRN: begin
        lamps_d = c_lamps_b_grn;
        dv_d    = 1'b1;
      end
      S_B_YEL: begin
        lamps_d = c_lamps_b_yel;
        dv_d    = 1'b1;
      end
      S_FORCE: begin
        if (force_a && !force_b) begin
          lamps_d = c_lamps_a_grn;
        end else if (force_b && !force_a) begin
          lamps_d = c_lamps_b_grn;
        end else begin
          lamps_d = c_lamps_red;
        end
      end
      S_FLASH: begin
        lamps_d = {1'b0, flash_y_d, 1'b0, 1'b0, flash_y_d, 1'b0};
      end
      default: ;
    endcase
    tick_d = (dv_d || (state_d == S_FLASH)) && !w_freeze && (presc_d == c_presc_tc);
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk_in or posedge clr) begin
    if (clr) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      cnt_a_q   <= '0;
      cnt_b_q   <= '0;
      flash_y_q <= 1'b0;
      tick_q    <= 1'b0;
      dv_q      <= 1'b0;
      lamps_q   <= c_lamps_red;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      cnt_a_q   <= cnt_a_d;
      cnt_b_q   <= cnt_b_d;
      flash_y_q <= flash_y_d;
      tick_q    <= tick_d;
      dv_q      <= dv_d;
      lamps_q   <= lamps_d;
    end
  end

  assign {r_a, y_a, g_a, r_b, y_b, g_b} = lamps_q;
  assign cnt_a      = cnt_a_q;
  assign cnt_b      = cnt_b_q;
  assign disp_valid = dv_q;
  assign tick       = tick_q;
  assign state      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_ctrl_param
// Purpose  : Self-checking bench for traffic_ctrl_param. A reference model
//            tracks elapsed seconds in the cycle and derives lamps/counters
//            arithmetically; directed steps are followed by random stimulus.
// Revision : 1.0  initial release
// ============================================================================
module tb_traffic_ctrl_param;

  localparam int TD    = 4;
  localparam int GA    = 3;
  localparam int GB    = 2;
  localparam int YL    = 1;
  localparam int CW    = 8;
  localparam int TOTAL = GA + YL + GB + YL;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_FORCE = 2;
  localparam int M_FLASH = 3;

  logic          clk_in  = 1'b0;
  logic          clr     = 1'b0;
  logic          start   = 1'b0;
  logic          force_a = 1'b0;
  logic          force_b = 1'b0;
  logic          flash   = 1'b0;
  logic          pause   = 1'b0;
  logic          r_a, y_a, g_a, r_b, y_b, g_b;
  logic [CW-1:0] cnt_a, cnt_b;
  logic          disp_valid, tick;
  logic [2:0]    state;

  int checks   = 0;
  int failures = 0;

  // Reference model state: mode, elapsed whole seconds in the cycle, prescaler
  int   m_mode   = M_IDLE;
  int   m_e      = 0;
  int   m_presc  = 0;
  logic m_fy     = 1'b0;
  logic m_frozen = 1'b0;
  logic m_fa     = 1'b0;
  logic m_fb     = 1'b0;

  traffic_ctrl_param #(
    .TICK_DIV(TD), .G_A(GA), .G_B(GB), .Y(YL), .CNT_W(CW)
  ) dut (
    .clk_in(clk_in), .clr(clr), .start(start), .force_a(force_a),
    .force_b(force_b), .flash(flash), .pause(pause),
    .r_a(r_a), .y_a(y_a), .g_a(g_a), .r_b(r_b), .y_b(y_b), .g_b(g_b),
    .cnt_a(cnt_a), .cnt_b(cnt_b), .disp_valid(disp_valid), .tick(tick),
    .state(state)
  );

  initial forever #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_e = 0; m_presc = 0;
    m_fy = 1'b0; m_frozen = 1'b0; m_fa = 1'b0; m_fb = 1'b0;
  endtask

  task automatic model_step();
    m_frozen = 1'b0;
    m_fa = force_a;
    m_fb = force_b;
    if (force_a || force_b) begin
      m_mode = M_FORCE; m_presc = 0;
    end else if (flash) begin
      if (m_mode != M_FLASH) begin
        m_mode = M_FLASH; m_presc = 0; m_fy = 1'b1;
      end else if (m_presc == TD - 1) begin
        m_presc = 0; m_fy = ~m_fy;
      end else begin
        m_presc++;
      end
    end else if (m_mode == M_RUN && pause) begin
      m_frozen = 1'b1;
    end else if (m_mode != M_RUN) begin
      m_presc = 0;
      if (start) begin m_mode = M_RUN; m_e = 0; end
      else m_mode = M_IDLE;
    end else if (m_presc == TD - 1) begin
      m_presc = 0;
      m_e++;
      if (m_e == TOTAL) begin
        if (start) m_e = 0;
        else m_mode = M_IDLE;
      end
    end else begin
      m_presc++;
    end
  endtask

  // {state, r_a, y_a, g_a, r_b, y_b, g_b, cnt_a, cnt_b, disp_valid, tick}
  function automatic logic [26:0] model_out();
    int   st = 0, ca = 0, cb = 0;
    logic ra = 1'b0, ya = 1'b0, ga = 1'b0, rb = 1'b0, yb = 1'b0, gb = 1'b0;
    logic dv = 1'b0, tk;
    case (m_mode)
      M_IDLE: begin st = 0; ra = 1'b1; rb = 1'b1; end
      M_FORCE: begin
        st = 5;
        if (m_fa && !m_fb) begin ga = 1'b1; rb = 1'b1; end
        else if (m_fb && !m_fa) begin ra = 1'b1; gb = 1'b1; end
        else begin ra = 1'b1; rb = 1'b1; end
      end
      M_FLASH: begin st = 6; ya = m_fy; yb = m_fy; end
      default: begin
        dv = 1'b1;
        if (m_e < GA) st = 1;
        else if (m_e < GA + YL) st = 2;
        else if (m_e < GA + YL + GB) st = 3;
        else st = 4;
        ga = (st == 1); ya = (st == 2); ra = (st >= 3);
        rb = (st <= 2); gb = (st == 3); yb = (st == 4);
        ca = (m_e < GA) ? GA - m_e : (m_e < GA + YL) ? GA + YL - m_e : TOTAL - m_e;
        cb = (m_e < GA + YL) ? GA + YL - m_e :
             (m_e < GA + YL + GB) ? GA + YL + GB - m_e : TOTAL - m_e;
      end
    endcase
    tk = (m_mode == M_RUN || m_mode == M_FLASH) && !m_frozen && (m_presc == TD - 1);
    return {st[2:0], ra, ya, ga, rb, yb, gb, ca[7:0], cb[7:0], dv, tk};
  endfunction

  function automatic logic [26:0] dut_out();
    return {state, r_a, y_a, g_a, r_b, y_b, g_b, cnt_a, cnt_b, disp_valid, tick};
  endfunction

  task automatic cyc();
    @(posedge clk_in);
    if (clr) model_reset();
    else model_step();
    #1;
  endtask

  task automatic cyc_chk(input string tag);
    cyc();
    chk(tag, {5'b0, dut_out()}, {5'b0, model_out()});
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget, input string tag);
    int n = 0;
    while (state !== target && n < budget) begin
      cyc_chk(tag);
      n++;
    end
    chk(tag, state, target);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_lamps"}, {r_a, y_a, g_a, r_b, y_b, g_b}, 6'b100100);
    chk({tag, "_cnt"}, {cnt_a, cnt_b}, 16'h0000);
    chk({tag, "_dv_tick"}, {disp_valid, tick}, 2'b00);
  endtask

  initial begin
    // Asynchronous reset before any clock edge
    #2 clr = 1'b1;
    #1;
    chk_reset_values("rst_async");
    model_reset();
    cyc_chk("rst_hold");
    cyc_chk("rst_hold");
    clr = 1'b0;
    cyc_chk("idle_no_start");

    // Normal cycle
    start = 1'b1;
    cyc_chk("start_edge");
    chk("start_state", state, 1);
    chk("start_lamps", {r_a, y_a, g_a, r_b, y_b, g_b}, 6'b001100);
    chk("start_cnt", {cnt_a, cnt_b}, 16'h0304);
    chk("start_dv", disp_valid, 1'b1);
    for (int k = 1; k <= 28; k++) begin
      cyc_chk("run_cycle");
      if (k == 4)  chk("k4_cnt", {cnt_a, cnt_b}, 16'h0203);
      if (k == 12) chk("k12_ayel", {state, y_a, r_b, cnt_a, cnt_b}, {3'd2, 2'b11, 16'h0101});
      if (k == 16) chk("k16_bgrn", {state, r_a, g_b, cnt_a, cnt_b}, {3'd3, 2'b11, 16'h0302});
      if (k == 24) chk("k24_byel", {state, r_a, y_b, cnt_a, cnt_b}, {3'd4, 2'b11, 16'h0101});
      if (k == 28) chk("k28_wrap", {state, cnt_a, cnt_b}, {3'd1, 16'h0304});
    end

    // Pause at cnt_a=2 with the prescaler part-way through the second
    for (int i = 0; i < 6; i++) cyc_chk("pre_pause");
    chk("pre_pause_cnt", {cnt_a, cnt_b}, 16'h0203);
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc_chk("pause_hold");
      chk("pause_frozen", {state, r_a, y_a, g_a, r_b, y_b, g_b, cnt_a, cnt_b, tick},
          {3'd1, 6'b001100, 16'h0203, 1'b0});
    end
    pause = 1'b0;
    cyc_chk("pause_release");
    chk("resume_tick", {tick, cnt_a}, {1'b1, 8'd2});
    cyc_chk("pause_after");
    chk("resume_step", {cnt_a, cnt_b}, 16'h0102);

    // force_a during B_GRN, then release back to a fresh cycle
    wait_state(3'd3, 40, "reach_bgrn");
    force_a = 1'b1;
    cyc_chk("force_a");
    chk("force_a_out", {state, r_a, y_a, g_a, r_b, y_b, g_b, disp_valid, cnt_a, cnt_b},
        {3'd5, 6'b001100, 1'b0, 16'h0000});
    force_a = 1'b0;
    cyc_chk("force_release");
    chk("force_release_out", {state, cnt_a, cnt_b}, {3'd1, 16'h0304});

    // Both forces, then only force_a
    force_a = 1'b1;
    force_b = 1'b1;
    cyc_chk("force_both");
    chk("force_both_out", {state, r_a, y_a, g_a, r_b, y_b, g_b}, {3'd5, 6'b100100});
    force_b = 1'b0;
    cyc_chk("force_a_only");
    chk("force_a_only_out", {r_a, y_a, g_a, r_b, y_b, g_b}, 6'b001100);

    // Flash mode blink pattern
    force_a = 1'b0;
    flash   = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      cyc_chk("flash");
      chk("flash_y", {y_a, y_b}, (((i - 1) / 4) % 2 == 0) ? 2'b11 : 2'b00);
      chk("flash_rg", {r_a, g_a, r_b, g_b, disp_valid}, 5'b00000);
    end
    flash = 1'b0;
    cyc_chk("flash_exit");
    chk("flash_exit_out", {state, cnt_a, cnt_b}, {3'd1, 16'h0304});

    // clr between edges during A_YEL acts without a clock edge
    wait_state(3'd2, 40, "reach_ayel");
    #2 clr = 1'b1;
    #1;
    chk_reset_values("clr_async");
    model_reset();
    cyc_chk("clr_hold");
    start = 1'b0;
    clr   = 1'b0;
    for (int i = 0; i < 3; i++) cyc_chk("idle_after_clr");
    chk("idle_after_clr_state", state, 0);

    // Random stimulus against the model
    for (int blk = 0; blk < 150; blk++) begin
      int n;
      start   = ($urandom_range(0, 7) != 0);
      pause   = ($urandom_range(0, 5) == 0);
      flash   = ($urandom_range(0, 24) == 0);
      force_a = ($urandom_range(0, 24) == 0);
      force_b = ($urandom_range(0, 24) == 0);
      n = $urandom_range(1, 6);
      for (int j = 0; j < n; j++) cyc_chk("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
